morse_key_timer: RTL

Front end of the Morse text path: turns one raw, bouncing push-button (the straight key) into the `dot`, `dash` and `char_end` one-cycle pulses that the Morse decoder consumes. The block synchronises and debounces the key, measures each press to tell a dot from a dash, and measures release gaps to mark character boundaries. It sits between the board button pin and the Morse decoder, in the same 100 MHz domain as the VGA text path.

---
 rtl/morse_key_timer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/morse_key_timer.sv
// morse_key_timer: straight-key front end for the Morse text path.
// Synchronises and debounces the raw key, classifies each press as a dot or
// a dash, and marks character boundaries from the release gap. Word-gap
// detection (word_end) is built only when MORSE_WORD_GAP_EN is defined;
// otherwise word_end is tied low and the WGAP state does not exist.
module morse_key_timer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DOT_MAX_CYCLES  = 20_000_000,
  parameter int CHAR_GAP_CYCLES = 40_000_000,
  parameter int WORD_GAP_CYCLES = 100_000_000,
  parameter int MAX_SYMBOLS     = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_clean,
  output logic dot,
  output logic dash,
  output logic char_end,
  output logic word_end
);

  localparam int CW = $clog2(WORD_GAP_CYCLES + 1);
  localparam int SW = $clog2(MAX_SYMBOLS + 1);

  // Compare against "last value before reaching N": the register update on
  // that edge is the one where the count reaches N.
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DOT_LAST  = CW'(DOT_MAX_CYCLES - 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(CHAR_GAP_CYCLES - 1);
  localparam logic [SW-1:0] SYM_LAST  = SW'(MAX_SYMBOLS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;
`ifdef MORSE_WORD_GAP_EN
  localparam logic [1:0] WGAP       = 2'd3;
  localparam logic [CW-1:0] WORD_LAST = CW'(WORD_GAP_CYCLES - 1);
  localparam logic [1:0] AFTER_CHAR = WGAP;
`else
  localparam logic [1:0] AFTER_CHAR = IDLE;
`endif

  logic          key_meta;
  logic          key_s;
  logic [CW-1:0] db_cnt;
  logic          db_flip;
  logic          rise;
  logic          fall;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sym_cnt;
  logic          force_end;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Two-flop synchroniser for the asynchronous key pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key;
      key_s    <= key_meta;
    end
  end

  // The FSM acts on the same edge that key_clean changes, so dot/dash line
  // up with the key_clean falling edge.
  assign db_flip = (key_s != key_clean) && (db_cnt == DB_LAST);
  assign rise    = db_flip && key_s;
  assign fall    = db_flip && !key_s;

  // Debounce: key_clean follows key_s only after a long enough mismatch run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt    <= '0;
      key_clean <= 1'b0;
    end else if (db_flip) begin
      db_cnt    <= '0;
      key_clean <= key_s;
    end else if (key_s != key_clean) begin
      db_cnt <= sat_inc(db_cnt);
    end else begin
      db_cnt <= '0;
    end
  end

  // Symbol FSM: times presses and release gaps and emits one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sym_cnt   <= '0;
      force_end <= 1'b0;
      dot       <= 1'b0;
      dash      <= 1'b0;
      char_end  <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
      word_end  <= 1'b0;
`endif
    end else begin
      dot       <= 1'b0;
      dash      <= 1'b0;
      // A forced boundary lands one cycle after its dot/dash.
      char_end  <= force_end;
      force_end <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
      word_end  <= 1'b0;
`endif
      cnt <= sat_inc(cnt);
      if (rise) begin
        // A new press abandons any pending character or word boundary.
        state <= PRESSED;
        cnt   <= '0;
      end else begin
        case (state)
          PRESSED: begin
            if (fall) begin
              // cnt holds (press length - 1) on this edge.
              if (cnt < DOT_LAST) dot <= 1'b1;
              else                dash <= 1'b1;
              cnt <= '0;
              if (sym_cnt == SYM_LAST) begin
                sym_cnt   <= '0;
                force_end <= 1'b1;
                state     <= AFTER_CHAR;
              end else begin
                sym_cnt <= sym_cnt + 1'b1;
                state   <= GAP;
              end
            end
          end
          GAP: begin
            if (cnt == CHAR_LAST) begin
              char_end <= 1'b1;
              sym_cnt  <= '0;
              state    <= AFTER_CHAR;
            end
          end
`ifdef MORSE_WORD_GAP_EN
          WGAP: begin
            // cnt keeps running from the last release through char_end.
            if (cnt == WORD_LAST) begin
              word_end <= 1'b1;
              state    <= IDLE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifndef MORSE_WORD_GAP_EN
  assign word_end = 1'b0;
`endif

endmodule
